alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the wait cycles (legal 0..15) between operand latch and result capture.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-006 SHALL have port cmd_op  input  2  operation: 00 ADD, 01 SUB, 10 ABS, 11 ASR.
REQ-007 SHALL have port cmd_load  input  1  load operand into the accumulator and ignore cmd_op.
REQ-008 SHALL have port cmd_operand  input  4  B operand, two's complement.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port res_data  output  4  result value.
REQ-012 SHALL have port res_overflow, res_zero  output  1 each  per-result flags.
REQ-013 SHALL have port acc  output  4  current accumulator (operand A).
REQ-014 SHALL have port ovf_sticky  output  1  latched overflow; port clr_sticky  input  1  clears it.

Function
REQ-015 SHALL run the FSM states IDLE, SETTLE, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-016 SHALL, on a handshake (cmd_valid & cmd_ready), latch op, load and operand; it SHALL enter SETTLE with count 0, or enter RESP on the next edge if cmd_load=1 or SETTLE_CYCLES=0.
REQ-017 SHALL, in SETTLE, drive the datapath with A=acc and B=latched operand, and count the cycles; after SETTLE_CYCLES cycles it SHALL capture the result and flags and enter RESP.
REQ-018 SHALL set the arithmetic latency to exactly SETTLE_CYCLES+1 cycles from the accept edge to res_valid=1, and the load latency to exactly 1 cycle.
REQ-019 SHALL compute, with s the raw 4-bit sum: ADD s=A+B; SUB s=A-B; ABS s=A-B and result=|s|; ASR s=A+B and result={s[3],s[3:1]}.
REQ-020 SHALL set res_overflow to the signed overflow of s (carry into bit 3 XOR carry out) for every arithmetic op.
REQ-021 SHALL set res_zero = (s==0) on the raw s, not on the result.
REQ-022 SHALL return |-8| as 4'b1000 for ABS, with overflow taken from the subtraction.
REQ-023 SHALL, for a load, set res_data=operand, res_overflow=0, res_zero=(operand==0).
REQ-024 SHALL hold res_valid and the result stable in RESP until res_ready=1; on that edge acc<=res_data and the FSM goes to IDLE.
REQ-025 SHALL keep acc unchanged when res_ready stays low; there SHALL be no timeout.
REQ-026 SHALL set ovf_sticky on the RESP handshake if res_overflow=1, and clear it on clr_sticky=1; set SHALL win over a simultaneous clear.
REQ-027 SHALL ignore cmd_valid outside IDLE; no queuing.

Reset
REQ-028 SHALL, when rst_n=0 at an edge and from any state, force IDLE, acc=0, res_data=0, res_valid=0, res_overflow=0, res_zero=0, ovf_sticky=0, count=0, and abort any operation in flight.
REQ-029 SHALL hold cmd_ready=0 while rst_n=0 and set it to 1 in the first cycle after release.

Structure
REQ-030 SHALL take from package alu_seq_pkg: DATA_W=4, the op encodings OP_ADD/OP_SUB/OP_ABS/OP_ASR, and the state enum.
REQ-031 SHALL place the purely combinational arithmetic (REQ-019..022) in sub-module alu4_datapath; the FSM, counter and registers SHALL stay in alu_sequencer.

Verification
REQ-032 Load 3, then ADD 4 SHALL give res_data=7, ovf=0, zero=0 with res_valid exactly 3 cycles after accept (SETTLE_CYCLES=2); acc=7 after the handshake.
REQ-033 acc=7 with ADD 1 SHALL give res_data=8, ovf=1; ovf_sticky=1 after the handshake; clr_sticky together with a new overflow SHALL leave it at 1.
REQ-034 acc=5 with SUB 5 SHALL give res_data=0, zero=1, ovf=0; acc=2 with ABS 6 SHALL give res_data=4, zero=0.
REQ-035 acc=6 with ASR 3 SHALL give s=9 and res_data=4'b1100, ovf=1; acc=8 with ABS 0 SHALL give res_data=8, ovf=0.
REQ-036 res_ready held low for 5 cycles SHALL keep res_valid and res_data stable and cmd_ready=0, and a cmd_valid pulse meanwhile SHALL be ignored.
REQ-037 rst_n low during SETTLE SHALL give IDLE, acc=0, res_valid=0 after one edge, then cmd_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the 4-bit accumulator sequencer: data width,
// operation encodings and the sequencer state enum.
package alu_seq_pkg;

  localparam int DATA_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ABS = 2'b10;
  localparam logic [1:0] OP_ASR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/alu4_datapath.sv
// Purely combinational 4-bit arithmetic: raw sum s, post-processed result,
// signed overflow of s and zero flag of s.
module alu4_datapath
  import alu_seq_pkg::*;
(
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_overflow,
  output logic              o_zero
);

  logic              w_sub;
  logic [DATA_W-1:0] w_b_eff;
  logic [3:0]        w_low;
  logic [DATA_W:0]   w_full;
  logic [DATA_W-1:0] w_s;

  // Subtraction is A + ~B + 1 so both carries come from one adder.
  assign w_sub   = (i_op == OP_SUB) || (i_op == OP_ABS);
  assign w_b_eff = w_sub ? ~i_b : i_b;
  assign w_low   = {1'b0, i_a[2:0]} + {1'b0, w_b_eff[2:0]} + {3'b000, w_sub};
  assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {4'b0000, w_sub};
  assign w_s     = w_full[DATA_W-1:0];

  assign o_overflow = w_low[3] ^ w_full[DATA_W];
  assign o_zero     = (w_s == '0);

  // |-8| wraps to 4'b1000, which is the intended encoding.
  always_comb begin
    o_result = w_s;
    case (i_op)
      OP_ABS:  o_result = w_s[DATA_W-1] ? (4'd0 - w_s) : w_s;
      OP_ASR:  o_result = {w_s[DATA_W-1], w_s[DATA_W-1:1]};
      default: o_result = w_s;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command/response sequencer around a 4-bit accumulator ALU with a
// programmable settle delay between operand latch and result capture.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_load,
  input  logic [DATA_W-1:0] cmd_operand,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_overflow,
  output logic              res_zero,
  output logic [DATA_W-1:0] acc,
  output logic              ovf_sticky,
  input  logic              clr_sticky,
  output state_t            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both 1; res_valid/res_data stay stable until res_ready is seen.

  localparam logic [3:0] LAST_CNT = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [1:0]        r_op;
  logic              r_load;
  logic [DATA_W-1:0] r_operand;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_ovf;
  logic              r_res_zero;
  logic              r_sticky;

  logic              w_accept;
  logic              w_capture;
  logic              w_resp_hs;
  logic              w_in_idle;
  logic [1:0]        w_sel_op;
  logic              w_sel_load;
  logic [DATA_W-1:0] w_sel_b;
  logic [DATA_W-1:0] w_dp_result;
  logic              w_dp_ovf;
  logic              w_dp_zero;
  logic [DATA_W-1:0] w_cap_data;
  logic              w_cap_ovf;
  logic              w_cap_zero;

  // In IDLE the command bus feeds the datapath directly so that loads and
  // zero-settle operations can capture on the accept edge itself.
  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_sel_op   = w_in_idle ? cmd_op      : r_op;
  assign w_sel_load = w_in_idle ? cmd_load    : r_load;
  assign w_sel_b    = w_in_idle ? cmd_operand : r_operand;

  alu4_datapath u_datapath (
    .i_op       (w_sel_op),
    .i_a        (r_acc),
    .i_b        (w_sel_b),
    .o_result   (w_dp_result),
    .o_overflow (w_dp_ovf),
    .o_zero     (w_dp_zero)
  );

  assign w_cap_data = w_sel_load ? w_sel_b : w_dp_result;
  assign w_cap_ovf  = w_sel_load ? 1'b0 : w_dp_ovf;
  assign w_cap_zero = w_sel_load ? (w_sel_b == '0) : w_dp_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_resp_hs   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          if (cmd_load || (SETTLE_CYCLES == 0)) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (r_cnt == LAST_CNT) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          w_resp_hs   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op       <= OP_ADD;
      r_load     <= 1'b0;
      r_operand  <= '0;
      r_acc      <= '0;
      r_res_data <= '0;
      r_res_ovf  <= 1'b0;
      r_res_zero <= 1'b0;
      r_sticky   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op      <= cmd_op;
        r_load    <= cmd_load;
        r_operand <= cmd_operand;
      end
      if ((r_state == ST_SETTLE) && !w_capture) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= '0;
      end
      if (w_capture) begin
        r_res_data <= w_cap_data;
        r_res_ovf  <= w_cap_ovf;
        r_res_zero <= w_cap_zero;
      end
      if (w_resp_hs) begin
        r_acc <= r_res_data;
      end
      // A new overflow outranks a simultaneous clear request.
      if (w_resp_hs && r_res_ovf) begin
        r_sticky <= 1'b1;
      end else if (clr_sticky) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign cmd_ready    = rst_n & w_in_idle;
  assign res_valid    = (r_state == ST_RESP);
  assign res_data     = r_res_data;
  assign res_overflow = r_res_ovf;
  assign res_zero     = r_res_zero;
  assign acc          = r_acc;
  assign ovf_sticky   = r_sticky;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, stall/reset sequences and
// randomized commands checked against an integer-arithmetic reference model.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_load;
  logic [3:0] cmd_operand;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_overflow;
  logic       res_zero;
  logic [3:0] acc;
  logic       ovf_sticky;
  logic       clr_sticky;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_load     (cmd_load),
    .cmd_operand  (cmd_operand),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_overflow (res_overflow),
    .res_zero     (res_zero),
    .acc          (acc),
    .ovf_sticky   (ovf_sticky),
    .clr_sticky   (clr_sticky),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard helpers
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Reference model: signed integer arithmetic, returns {data, ovf, zero}.
  function automatic logic [5:0] model(input logic ld, input logic [1:0] op,
                                       input logic [3:0] a, input logic [3:0] b);
    int ai, bi, r, sv, res;
    logic o;
    if (ld) return {b, 1'b0, (b == 4'd0)};
    ai = a[3] ? int'(a) - 16 : int'(a);
    bi = b[3] ? int'(b) - 16 : int'(b);
    r  = (op == OP_ADD || op == OP_ASR) ? ai + bi : ai - bi;
    o  = (r > 7) || (r < -8);
    sv = (r > 7) ? r - 16 : ((r < -8) ? r + 16 : r);
    case (op)
      OP_ABS:  res = (sv < 0) ? -sv : sv;
      OP_ASR:  res = (sv >= 0) ? sv / 2 : -((-sv + 1) / 2);
      default: res = sv;
    endcase
    return {4'(res), o, (sv == 0)};
  endfunction

  // Driver tasks
  task automatic issue(input logic ld, input logic [1:0] op, input logic [3:0] b,
                       output int lat);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("cmd_ready_before_issue", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_operand = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic complete();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic       ld;
    logic [1:0] op;
    logic [3:0] b;
    logic [3:0] exp_d;
    logic       exp_o;
    logic       exp_z;
  } vec_t;

  vec_t       vecs[12];
  logic [3:0] m_acc;
  logic       m_sticky;
  logic [5:0] exp_r;
  int         lat;

  initial begin
    vecs[0]  = '{1'b1, OP_ADD, 4'd3,  4'd3,  1'b0, 1'b0};
    vecs[1]  = '{1'b0, OP_ADD, 4'd4,  4'd7,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, OP_ADD, 4'd1,  4'd8,  1'b1, 1'b0};
    vecs[3]  = '{1'b1, OP_SUB, 4'd5,  4'd5,  1'b0, 1'b0};
    vecs[4]  = '{1'b0, OP_SUB, 4'd5,  4'd0,  1'b0, 1'b1};
    vecs[5]  = '{1'b1, OP_ABS, 4'd2,  4'd2,  1'b0, 1'b0};
    vecs[6]  = '{1'b0, OP_ABS, 4'd6,  4'd4,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, OP_ASR, 4'd6,  4'd6,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, OP_ASR, 4'd3,  4'hC,  1'b1, 1'b0};
    vecs[9]  = '{1'b1, OP_ADD, 4'h8,  4'h8,  1'b0, 1'b0};
    vecs[10] = '{1'b0, OP_ABS, 4'd0,  4'h8,  1'b0, 1'b0};
    vecs[11] = '{1'b1, OP_ASR, 4'd0,  4'd0,  1'b0, 1'b1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_load = 1'b0;
    cmd_operand = 4'd0; res_ready = 1'b0; clr_sticky = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_acc", int'(acc), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_sticky", int'(ovf_sticky), 0);
    chk("rst_state", int'(dbg_state), int'(ST_IDLE));
    rst_n = 1'b1;
    #1;
    chk("release_cmd_ready", int'(cmd_ready), 1);
    m_acc = 4'd0; m_sticky = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].ld, vecs[i].op, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].ld ? 1 : 3);
      chk($sformatf("vec%0d_data", i), int'(res_data), int'(vecs[i].exp_d));
      chk($sformatf("vec%0d_ovf", i), int'(res_overflow), int'(vecs[i].exp_o));
      chk($sformatf("vec%0d_zero", i), int'(res_zero), int'(vecs[i].exp_z));
      chk($sformatf("vec%0d_ready_low", i), int'(cmd_ready), 0);
      complete();
      m_sticky = m_sticky | vecs[i].exp_o;
      chk($sformatf("vec%0d_acc", i), int'(acc), int'(vecs[i].exp_d));
      chk($sformatf("vec%0d_sticky", i), int'(ovf_sticky), int'(m_sticky));
    end
    m_acc = 4'd0;

    // Sticky clear, then clear coinciding with a new overflow
    clr_sticky = 1'b1; @(posedge clk); #1; clr_sticky = 1'b0;
    chk("sticky_cleared", int'(ovf_sticky), 0);
    issue(1'b1, OP_ADD, 4'd7, lat);
    complete();
    issue(1'b0, OP_ADD, 4'd1, lat);
    chk("clr_race_ovf", int'(res_overflow), 1);
    clr_sticky = 1'b1;
    complete();
    clr_sticky = 1'b0;
    chk("clr_race_sticky", int'(ovf_sticky), 1);
    chk("clr_race_acc", int'(acc), 8);
    m_acc = 4'd8; m_sticky = 1'b1;

    // Response stall with an ignored command pulse
    exp_r = model(1'b0, OP_SUB, m_acc, 4'd3);
    issue(1'b0, OP_SUB, 4'd3, lat);
    chk("stall_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = 4'd9;
      end
      if (i == 2) cmd_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", i), int'(res_valid), 1);
      chk($sformatf("stall%0d_data", i), int'(res_data), int'(exp_r[5:2]));
      chk($sformatf("stall%0d_cmd_ready", i), int'(cmd_ready), 0);
      chk($sformatf("stall%0d_acc", i), int'(acc), int'(m_acc));
    end
    cmd_valid = 1'b0; cmd_load = 1'b0;
    complete();
    m_acc = exp_r[5:2];
    m_sticky = m_sticky | exp_r[1];
    chk("stall_acc_after", int'(acc), int'(m_acc));
    repeat (2) @(posedge clk);
    #1;
    chk("stall_no_queued_cmd", int'(res_valid), 0);
    chk("stall_idle", int'(dbg_state), int'(ST_IDLE));

    // Reset during SETTLE
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_ADD; cmd_operand = 4'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("abort_in_settle", int'(dbg_state), int'(ST_SETTLE));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_state", int'(dbg_state), int'(ST_IDLE));
    chk("abort_acc", int'(acc), 0);
    chk("abort_res_valid", int'(res_valid), 0);
    chk("abort_cmd_ready", int'(cmd_ready), 0);
    chk("abort_sticky", int'(ovf_sticky), 0);
    rst_n = 1'b1;
    #1;
    chk("abort_release_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    chk("abort_stays_idle", int'(res_valid), 0);
    m_acc = 4'd0; m_sticky = 1'b0;

    // Randomized commands against the reference model
    for (int n = 0; n < 150; n++) begin
      logic       r_ld;
      logic [1:0] r_op;
      logic [3:0] r_b;
      int         stall;
      r_ld  = ($urandom_range(0, 3) == 0);
      r_op  = 2'($urandom_range(0, 3));
      r_b   = 4'($urandom_range(0, 15));
      stall = $urandom_range(0, 3);
      exp_r = model(r_ld, r_op, m_acc, r_b);
      issue(r_ld, r_op, r_b, lat);
      chk($sformatf("rnd%0d_latency", n), lat, r_ld ? 1 : 3);
      chk($sformatf("rnd%0d_data", n), int'(res_data), int'(exp_r[5:2]));
      chk($sformatf("rnd%0d_ovf", n), int'(res_overflow), int'(exp_r[1]));
      chk($sformatf("rnd%0d_zero", n), int'(res_zero), int'(exp_r[0]));
      repeat (stall) @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_held", n), int'(res_data), int'(exp_r[5:2]));
      complete();
      m_acc    = exp_r[5:2];
      m_sticky = m_sticky | exp_r[1];
      chk($sformatf("rnd%0d_acc", n), int'(acc), int'(m_acc));
      chk($sformatf("rnd%0d_sticky", n), int'(ovf_sticky), int'(m_sticky));
      if ($urandom_range(0, 7) == 0) begin
        clr_sticky = 1'b1; @(posedge clk); #1; clr_sticky = 1'b0;
        m_sticky = 1'b0;
        chk($sformatf("rnd%0d_clr", n), int'(ovf_sticky), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
